// File: rtl/dll_ack_nak_gen.sv
// Receive-side DLL: checks TLP sequence/LCRC, forwards in-order good TLPs, generates coalesced ACK/NAK DLLPs.
// Latency: forward 1 cycle; NAK/duplicate-ACK 1 cycle; timer ACK ACK_LATENCY cycles after first unacked TLP.
// Backpressure: none on rx; pending DLLP held until dllp_ready, with seq tracking and ACK->NAK escalation.
module dll_ack_nak_gen #(
    parameter int ACK_LATENCY  = 16,
    parameter int ACK_COALESCE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [11:0] rx_seq,
    input  logic        rx_crc_ok,
    input  logic [63:0] rx_data,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [1:0]  ack_nak,
    output logic [11:0] seq,
    input  logic        dllp_ready,
    output logic        nak_scheduled
);

    localparam int TW = (ACK_LATENCY > 2) ? $clog2(ACK_LATENCY) : 1;
    localparam int CW = $clog2(ACK_COALESCE + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_LATENCY - 1);
    localparam logic [CW-1:0] COAL_MAX  = CW'(ACK_COALESCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_NAK  = 2'b10
    } dllp_state_t;

    dllp_state_t   state_q, state_nxt;
    logic [11:0]   next_rcv_seq;
    logic [11:0]   seq_dist;
    logic [TW-1:0] timer_cnt;
    logic          timer_on;
    logic [CW-1:0] good_cnt;

    logic is_bad, is_good, is_dup, is_ahead;
    logic nak_sched, ack_sched, timer_fire, coal_fire, clear_ack_state;

    always_comb begin
        seq_dist   = next_rcv_seq - rx_seq;
        is_bad     = rx_valid && !rx_crc_ok;
        is_good    = rx_valid && rx_crc_ok && (seq_dist == 12'd0);
        is_dup     = rx_valid && rx_crc_ok && (seq_dist != 12'd0) && (seq_dist <= 12'd2048);
        is_ahead   = rx_valid && rx_crc_ok && !is_good && !is_dup;
        nak_sched  = (is_bad || is_ahead) && !nak_scheduled;
        timer_fire = timer_on && (timer_cnt == TIMER_MAX);
        coal_fire  = is_good && (good_cnt == COAL_MAX);
        ack_sched  = is_dup || timer_fire || coal_fire;
        // A NAK implicitly acknowledges everything before its seq, so it also restarts coalescing.
        clear_ack_state = nak_sched || timer_fire || coal_fire;
    end

    always_comb begin
        state_nxt = state_q;
        if (nak_sched) begin
            state_nxt = ST_NAK;
        end else if (ack_sched && (state_q != ST_NAK || dllp_ready)) begin
            state_nxt = ST_ACK;
        end else if (state_q != ST_IDLE && dllp_ready) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            next_rcv_seq  <= 12'd0;
            nak_scheduled <= 1'b0;
            timer_on      <= 1'b0;
            timer_cnt     <= '0;
            good_cnt      <= '0;
            out_valid     <= 1'b0;
            out_data      <= 64'd0;
        end else begin
            state_q   <= state_nxt;
            out_valid <= is_good;
            if (is_good) begin
                out_data     <= rx_data;
                next_rcv_seq <= next_rcv_seq + 12'd1;
            end

            if (is_good) begin
                nak_scheduled <= 1'b0;
            end else if (nak_sched) begin
                nak_scheduled <= 1'b1;
            end

            if (clear_ack_state) begin
                timer_on  <= 1'b0;
                timer_cnt <= '0;
                good_cnt  <= '0;
            end else begin
                if (timer_on) begin
                    timer_cnt <= timer_cnt + TW'(1);
                end else if (is_good) begin
                    timer_on  <= 1'b1;
                    timer_cnt <= '0;
                end
                if (is_good) begin
                    good_cnt <= good_cnt + CW'(1);
                end
            end
        end
    end

    assign ack_nak = state_q;
    assign seq     = next_rcv_seq - 12'd1;

endmodule

// File: tb/tb_dll_ack_nak_gen.sv
// Directed bench for dll_ack_nak_gen: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_dll_ack_nak_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [11:0] rx_seq;
    logic        rx_crc_ok;
    logic [63:0] rx_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  ack_nak;
    logic [11:0] seq;
    logic        dllp_ready;
    logic        nak_scheduled;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dll_ack_nak_gen #(.ACK_LATENCY(16), .ACK_COALESCE(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_seq        (rx_seq),
        .rx_crc_ok     (rx_crc_ok),
        .rx_data       (rx_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .ack_nak       (ack_nak),
        .seq           (seq),
        .dllp_ready    (dllp_ready),
        .nak_scheduled (nak_scheduled)
    );

    function automatic logic [63:0] pat(input logic [11:0] s);
        return {16'hC0DE, 36'h0, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] s, input logic ok);
        rx_valid  = 1'b1;
        rx_seq    = s;
        rx_crc_ok = ok;
        rx_data   = pat(s);
        step();
    endtask

    task automatic idle_in();
        rx_valid  = 1'b0;
        rx_crc_ok = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_seq     = 12'd0;
        rx_crc_ok  = 1'b0;
        rx_data    = 64'd0;
        dllp_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset values
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_ack_nak", 64'(ack_nak), 64'd0);
        check("rst_seq", 64'(seq), 64'hFFF);
        check("rst_nak_sched", 64'(nak_scheduled), 64'd0);

        // Eight in-order TLPs: coalesced ACK right after the 8th
        for (int i = 0; i < 8; i++) begin
            send(12'(i), 1'b1);
            check("coal_out_valid", 64'(out_valid), 64'd1);
            check("coal_out_data", out_data, pat(12'(i)));
            if (i < 7) check("coal_no_ack", 64'(ack_nak), 64'd0);
        end
        check("coal_ack", 64'(ack_nak), 64'd1);
        check("coal_seq", 64'(seq), 64'd7);
        idle_in();
        step();
        check("coal_out_idle", 64'(out_valid), 64'd0);
        check("coal_ack_taken", 64'(ack_nak), 64'd0);

        // Bad LCRC -> single NAK, ahead TLP dropped, resend clears
        do_reset();
        send(12'd0, 1'b1);
        send(12'd1, 1'b1);
        send(12'd2, 1'b0);
        check("nak_type", 64'(ack_nak), 64'd2);
        check("nak_seq", 64'(seq), 64'd1);
        check("nak_flag", 64'(nak_scheduled), 64'd1);
        check("nak_bad_dropped", 64'(out_valid), 64'd0);
        send(12'd3, 1'b1);
        check("ahead_no_2nd_nak", 64'(ack_nak), 64'd0);
        check("ahead_flag_held", 64'(nak_scheduled), 64'd1);
        check("ahead_dropped", 64'(out_valid), 64'd0);
        check("ahead_seq", 64'(seq), 64'd1);
        send(12'd2, 1'b1);
        check("retry_fwd", 64'(out_valid), 64'd1);
        check("retry_data", out_data, pat(12'd2));
        check("retry_flag_clr", 64'(nak_scheduled), 64'd0);
        check("retry_seq", 64'(seq), 64'd2);
        idle_in();

        // Duplicate -> immediate ACK, not forwarded
        do_reset();
        for (int i = 0; i < 5; i++) send(12'(i), 1'b1);
        send(12'd2, 1'b1);
        check("dup_ack", 64'(ack_nak), 64'd1);
        check("dup_seq", 64'(seq), 64'd4);
        check("dup_dropped", 64'(out_valid), 64'd0);
        idle_in();

        // Timer ACK exactly 16 cycles after a lone TLP
        do_reset();
        send(12'd0, 1'b1);
        idle_in();
        check("tmr_fwd", 64'(out_valid), 64'd1);
        for (int k = 1; k <= 15; k++) begin
            step();
            check("tmr_not_yet", 64'(ack_nak), 64'd0);
        end
        step();
        check("tmr_ack", 64'(ack_nak), 64'd1);
        check("tmr_seq", 64'(seq), 64'd0);

        // Held ACK escalates to NAK under backpressure
        do_reset();
        dllp_ready = 1'b0;
        send(12'd0, 1'b1);
        send(12'd0, 1'b1);
        check("hold_ack", 64'(ack_nak), 64'd1);
        check("hold_ack_seq", 64'(seq), 64'd0);
        idle_in();
        step();
        step();
        check("hold_ack_stable", 64'(ack_nak), 64'd1);
        send(12'd5, 1'b0);
        check("esc_nak", 64'(ack_nak), 64'd2);
        check("esc_flag", 64'(nak_scheduled), 64'd1);
        check("esc_seq", 64'(seq), 64'd0);
        idle_in();
        step();
        step();
        check("esc_nak_stable", 64'(ack_nak), 64'd2);
        dllp_ready = 1'b1;
        step();
        check("esc_accepted", 64'(ack_nak), 64'd0);

        // Sequence wrap-around
        do_reset();
        for (int i = 0; i < 4095; i++) send(12'(i), 1'b1);
        send(12'd4095, 1'b1);
        check("wrap_fwd_4095", 64'(out_valid), 64'd1);
        check("wrap_data_4095", out_data, pat(12'd4095));
        check("wrap_seq_4095", 64'(seq), 64'hFFF);
        check("wrap_coal_ack", 64'(ack_nak), 64'd1);
        send(12'd0, 1'b1);
        check("wrap_fwd_0", 64'(out_valid), 64'd1);
        check("wrap_data_0", out_data, pat(12'd0));
        check("wrap_seq_0", 64'(seq), 64'd0);
        check("wrap_ack_taken", 64'(ack_nak), 64'd0);
        idle_in();
        for (int k = 0; k < 16; k++) step();
        check("wrap_final_ack", 64'(ack_nak), 64'd1);
        check("wrap_final_seq", 64'(seq), 64'd0);

        // Reset with a pending ACK and a TLP in flight
        dllp_ready = 1'b0;
        reset = 1'b1;
        send(12'd1, 1'b1);
        reset = 1'b0;
        idle_in();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_ack_nak", 64'(ack_nak), 64'd0);
        check("mid_rst_seq", 64'(seq), 64'hFFF);
        check("mid_rst_nak_sched", 64'(nak_scheduled), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
